dot_product_sequencer: RTL and testbench

- Control stage directly upstream of the multiply-accumulate unit in the MLP datapath.
- Walks two N-element IEEE-754 single-precision vectors (inputs and weights) held in synchronous-read memories, one element per step, and presents each pair to the MAC with the running sum as the accumulator operand.
- Waits out the MAC's pipeline latency, captures the MAC result back into the running sum, and after element N-1 reports the final dot product to the activation stage with a one-cycle `done` pulse.

---
 rtl/mlp_pkg.sv | 21 ++
 rtl/dot_product_sequencer_if.sv | 40 ++++
 rtl/mac_wait_timer.sv | 35 +++
 rtl/dot_product_sequencer.sv | 131 +++++++++++++
 tb/tb_dot_product_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_pkg.sv
// Shared MLP datapath definitions: sequencer FSM states, FP constants and FPU
// control encodings used by the sequencer and the MAC.
package mlp_pkg;

    localparam int unsigned FP_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

    localparam logic [1:0] FPU_RM_DOWN = 2'b11;
    localparam logic [2:0] FPU_OP_ADD  = 3'b000;
    localparam logic [2:0] FPU_OP_MUL  = 3'b010;

endpackage

// File: rtl/dot_product_sequencer_if.sv
// Memory, MAC and control bundle of the dot-product sequencer.
// The bias operand exists only when DOT_BIAS_EN is defined.
interface dot_product_sequencer_if #(
    parameter int unsigned ADDR_W = 3
);
    import mlp_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic [FP_W-1:0]   result;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [FP_W-1:0]   a_data;
    logic [FP_W-1:0]   b_data;
    logic [FP_W-1:0]   mac_opA;
    logic [FP_W-1:0]   mac_opB;
    logic [FP_W-1:0]   mac_acc;
    logic [FP_W-1:0]   mac_result;
`ifdef DOT_BIAS_EN
    logic [FP_W-1:0]   bias;
`endif

    modport master (
`ifdef DOT_BIAS_EN
        input  bias,
`endif
        input  start, a_data, b_data, mac_result,
        output busy, done, result, a_addr, b_addr, mac_opA, mac_opB, mac_acc
    );

    modport slave (
`ifdef DOT_BIAS_EN
        output bias,
`endif
        output start, a_data, b_data, mac_result,
        input  busy, done, result, a_addr, b_addr, mac_opA, mac_opB, mac_acc
    );

endinterface

// File: rtl/mac_wait_timer.sv
// Loadable down-counter that flags the final cycle of the MAC latency window.
module mac_wait_timer #(
    parameter int unsigned MAC_LATENCY = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    output logic last_c
);
    localparam int unsigned CNT_W = $clog2(MAC_LATENCY + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(MAC_LATENCY);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Loaded to MAC_LATENCY in LOAD, so a count of one marks the last WAIT cycle.
    assign last_c = (cnt_q == CNT_W'(1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dot_product_sequencer.sv
// Sequences N operand pairs from the vector memories through an external MAC and
// reports the accumulated dot product. DOT_BIAS_EN seeds the sum from bus.bias.
module dot_product_sequencer
    import mlp_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned MAC_LATENCY = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    dot_product_sequencer_if.master  bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [FP_W-1:0]   opa_q, opa_d;
    logic [FP_W-1:0]   opb_q, opb_d;
    logic [FP_W-1:0]   acc_q, acc_d;
    logic [FP_W-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tmr_load_c;
    logic              tmr_last_c;
    logic [FP_W-1:0]   init_sum_c;

`ifdef DOT_BIAS_EN
    assign init_sum_c = bus.bias;
`else
    assign init_sum_c = FP_ZERO;
`endif

    mac_wait_timer #(
        .MAC_LATENCY (MAC_LATENCY)
    ) u_wait_timer (
        .CLK    (CLK),
        .RST    (RST),
        .load   (tmr_load_c),
        .last_c (tmr_last_c)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        result_d   = result_q;
        done_d     = 1'b0;
        tmr_load_c = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                    addr_d  = '0;
                    acc_d   = init_sum_c;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                opa_d      = bus.a_data;
                opb_d      = bus.b_data;
                tmr_load_c = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (tmr_last_c) begin
                    acc_d = bus.mac_result;
                    if (idx_q == LAST_IDX) begin
                        state_d  = ST_DONE;
                        result_d = bus.mac_result;
                        done_d   = 1'b1;
                    end else begin
                        // The address register leads idx so FETCH presents it from its first cycle.
                        idx_d   = idx_q + ADDR_W'(1);
                        addr_d  = idx_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_FETCH) || (state_d == ST_LOAD) || (state_d == ST_WAIT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            addr_q   <= '0;
            opa_q    <= FP_ZERO;
            opb_q    <= FP_ZERO;
            acc_q    <= FP_ZERO;
            result_q <= FP_ZERO;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.a_addr  = addr_q;
    assign bus.b_addr  = addr_q;
    assign bus.mac_opA = opa_q;
    assign bus.mac_opB = opb_q;
    assign bus.mac_acc = acc_q;
    assign bus.result  = result_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer: an N=4 instance driven from a vector
// table plus corner sequences, and an N=1 instance. Honours DOT_BIAS_EN.
module tb_dot_product_sequencer;
    import mlp_pkg::*;

    localparam int unsigned N    = 4;
    localparam int unsigned AW   = 3;
    localparam int unsigned LAT  = 2;
    localparam int unsigned EL   = 2 + LAT;
    localparam int unsigned RUN  = N * EL;
    localparam int unsigned NV   = 5;
    localparam logic [31:0] BIAS = 32'h3F80_0000;

    typedef struct packed {
        logic [N-1:0][31:0] a;
        logic [N-1:0][31:0] b;
        logic [31:0]        exp_nb;
        logic [31:0]        exp_b;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;
    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs [NV];

    logic [31:0] mem_a  [2**AW];
    logic [31:0] mem_b  [2**AW];
    logic [31:0] mem_a1 [2];
    logic [31:0] mem_b1 [2];
    logic [31:0] mac_pipe;
    logic [31:0] mac_pipe1;

    always #5 CLK = ~CLK;

    dot_product_sequencer_if #(.ADDR_W(AW)) bus ();
    dot_product_sequencer_if #(.ADDR_W(1))  bus1 ();

    dot_product_sequencer #(.N(N), .ADDR_W(AW), .MAC_LATENCY(LAT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    dot_product_sequencer #(.N(1), .ADDR_W(1), .MAC_LATENCY(LAT)) dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1)
    );

    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real  m;
        int   e;
        logic s;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
    endfunction

    function automatic logic [31:0] fmac(input logic [31:0] acc, input logic [31:0] x, input logic [31:0] y);
        return r2f(f2r(acc) + f2r(x) * f2r(y));
    endfunction

    function automatic logic [N-1:0][31:0] mk(input logic [31:0] e0, input logic [31:0] e1,
                                              input logic [31:0] e2, input logic [31:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    // Synchronous-read memories and a MAC with one register stage (latency 2).
    always @(posedge CLK) begin
        bus.a_data  <= mem_a[bus.a_addr];
        bus.b_data  <= mem_b[bus.b_addr];
        bus1.a_data <= mem_a1[bus1.a_addr];
        bus1.b_data <= mem_b1[bus1.b_addr];
        mac_pipe    <= fmac(bus.mac_acc, bus.mac_opA, bus.mac_opB);
        mac_pipe1   <= fmac(bus1.mac_acc, bus1.mac_opA, bus1.mac_opB);
    end
    assign bus.mac_result  = mac_pipe;
    assign bus1.mac_result = mac_pipe1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < int'(N); i++) begin
            mem_a[i] = v.a[i];
            mem_b[i] = v.b[i];
        end
    endtask

    task automatic kick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    function automatic logic [31:0] exp_result(input vec_t v);
`ifdef DOT_BIAS_EN
        return v.exp_b;
`else
        return v.exp_nb;
`endif
    endfunction

    // Called at the first sample after start was accepted (FETCH of element 0).
    task automatic run_body(input vec_t v, input bit extra, input bit chain);
        logic [31:0] acc;
        logic [31:0] res;
        int          ph;
        int          el;
`ifdef DOT_BIAS_EN
        acc = BIAS;
`else
        acc = FP_ZERO;
`endif
        res = exp_result(v);
        for (int k = 0; k <= int'(RUN); k++) begin
            ph = k % int'(EL);
            el = k / int'(EL);
            if (k < int'(RUN)) begin
                check("done_low", 32'(bus.done), 32'd0);
                if (ph == 0) begin
                    check("a_addr", 32'(bus.a_addr), 32'(el));
                    check("b_addr", 32'(bus.b_addr), 32'(el));
                    check("busy_run", 32'(bus.busy), 32'd1);
                end else if (ph >= 2) begin
                    check("wait_opA", bus.mac_opA, v.a[el]);
                    check("wait_opB", bus.mac_opB, v.b[el]);
                    check("wait_acc", bus.mac_acc, acc);
                    if (ph == int'(EL) - 1) acc = fmac(acc, v.a[el], v.b[el]);
                end
            end else begin
                check("done_pulse", 32'(bus.done), 32'd1);
                check("result", bus.result, res);
                check("busy_done", 32'(bus.busy), 32'd0);
            end
            bus.start = (extra && (k == 2 || k == 9)) || (chain && k == int'(RUN));
            tick();
        end
        bus.start = 1'b0;
        if (!chain) begin
            check("done_after", 32'(bus.done), 32'd0);
            check("busy_idle", 32'(bus.busy), 32'd0);
            check("result_hold", bus.result, res);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_a_addr", 32'(bus.a_addr), 32'd0);
        check("rst_b_addr", 32'(bus.b_addr), 32'd0);
        check("rst_opA", bus.mac_opA, 32'd0);
        check("rst_opB", bus.mac_opB, 32'd0);
        check("rst_acc", bus.mac_acc, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
    endtask

    initial begin
        vecs[0] = '{a: mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000),
                    b: mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000),
                    exp_nb: 32'h41000000, exp_b: 32'h41100000};
        vecs[1] = '{a: mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000),
                    b: mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000),
                    exp_nb: 32'h41200000, exp_b: 32'h41300000};
        vecs[2] = '{a: mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000),
                    b: mk(32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000),
                    exp_nb: 32'h00000000, exp_b: 32'h3F800000};
        vecs[3] = '{a: mk(32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000),
                    b: mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000),
                    exp_nb: 32'hC1000000, exp_b: 32'hC0E00000};
        vecs[4] = '{a: mk(32'h40400000, 32'h3F000000, 32'hBF800000, 32'h40800000),
                    b: mk(32'h40000000, 32'h40800000, 32'h40400000, 32'h3F000000),
                    exp_nb: 32'h40E00000, exp_b: 32'h41000000};

        for (int i = 0; i < 2**AW; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a1[0] = 32'h40400000;
        mem_b1[0] = 32'h40000000;
        mem_a1[1] = 32'h0;
        mem_b1[1] = 32'h0;

        RST        = 1'b1;
        bus.start  = 1'b0;
        bus1.start = 1'b0;
`ifdef DOT_BIAS_EN
        bus.bias   = BIAS;
        bus1.bias  = FP_ZERO;
`endif
        repeat (3) tick();
        check_reset_outputs();
        RST = 1'b0;
        tick();

        // Table of full runs.
        for (int i = 0; i < int'(NV); i++) begin
            load_vec(vecs[i]);
            kick();
            run_body(vecs[i], 1'b0, 1'b0);
        end

        // start pulses during the run are ignored.
        load_vec(vecs[0]);
        kick();
        run_body(vecs[0], 1'b1, 1'b0);

        // start held through DONE chains straight into FETCH.
        kick();
        run_body(vecs[0], 1'b0, 1'b1);
        check("chain_busy", 32'(bus.busy), 32'd1);
        run_body(vecs[0], 1'b0, 1'b0);

        // Reset during WAIT of element 2, with a coincident start.
        kick();
        repeat (2 * EL + 2) tick();
        RST       = 1'b1;
        bus.start = 1'b1;
        tick();
        check_reset_outputs();
        RST       = 1'b0;
        bus.start = 1'b0;
        tick();
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_done", 32'(bus.done), 32'd0);
        kick();
        run_body(vecs[0], 1'b0, 1'b0);

        // Single-element vector.
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int k = 0; k <= int'(EL); k++) begin
            if (k == 0) begin
                check("n1_addr", 32'(bus1.a_addr), 32'd0);
                check("n1_busy", 32'(bus1.busy), 32'd1);
            end
            if (k >= 2 && k < int'(EL)) begin
                check("n1_opA", bus1.mac_opA, 32'h40400000);
                check("n1_opB", bus1.mac_opB, 32'h40000000);
                check("n1_acc", bus1.mac_acc, 32'h0);
            end
            check("n1_done", 32'(bus1.done), (k == int'(EL)) ? 32'd1 : 32'd0);
            if (k == int'(EL)) check("n1_result", bus1.result, 32'h40C00000);
            tick();
        end
        check("n1_idle", 32'(bus1.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
